// File: rtl/dispatcher.sv
// rtl/dispatcher.sv - single-entry rename, operand-resolve and issue stage
//
// Ports:
//   clk, rst (sync, active-high), rdy (global enable), clear (flush, same as rst)
//   iq_*        decoded instruction in, iq_ready accept strobe out
//   rf_*        regfile lookup at iq_rs1/iq_rs2; rename_* destination rename out
//   rob_*       ROB tail/lookup in; rob_alloc/opcode/rd/pc allocation out
//   rs_full, lsb_full in; is_issue (Rs) / lsb_issue (LSB) plus shared issue_* bus out
//   is_alu_ok/is_lsb_ok/is_rob_commit with rob_id_from_*/res_from_* result broadcasts in

module dispatcher #(
  parameter int ROB_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             iq_valid,
  input  logic [5:0]       iq_opcode,
  input  logic [4:0]       iq_rd,
  input  logic [4:0]       iq_rs1,
  input  logic [4:0]       iq_rs2,
  input  logic [31:0]      iq_imm,
  input  logic [31:0]      iq_pc,
  input  logic             iq_use_rs1,
  input  logic             iq_use_rs2,
  input  logic             iq_is_mem,
  output logic             iq_ready,
  input  logic             rf_busy1,
  input  logic             rf_busy2,
  input  logic [ROB_W-1:0] rf_tag1,
  input  logic [ROB_W-1:0] rf_tag2,
  input  logic [31:0]      rf_val1,
  input  logic [31:0]      rf_val2,
  output logic             rename_en,
  output logic [4:0]       rename_rd,
  output logic [ROB_W-1:0] rename_tag,
  input  logic             rob_full,
  input  logic [ROB_W-1:0] rob_tail,
  input  logic             rob_q1_ready,
  input  logic             rob_q2_ready,
  input  logic [31:0]      rob_q1_val,
  input  logic [31:0]      rob_q2_val,
  output logic             rob_alloc,
  output logic [5:0]       rob_opcode,
  output logic [4:0]       rob_rd,
  output logic [31:0]      rob_pc,
  input  logic             rs_full,
  input  logic             lsb_full,
  output logic             is_issue,
  output logic             lsb_issue,
  output logic [5:0]       issue_opcode,
  output logic [ROB_W-1:0] issue_rob_id,
  output logic [31:0]      issue_Vi,
  output logic [ROB_W-1:0] issue_Qi,
  output logic             issue_Ri,
  output logic [31:0]      issue_Vj,
  output logic [ROB_W-1:0] issue_Qj,
  output logic             issue_Rj,
  output logic [31:0]      issue_imm,
  output logic [31:0]      issue_pc,
  input  logic             is_alu_ok,
  input  logic [ROB_W-1:0] rob_id_from_alu,
  input  logic [31:0]      res_from_alu,
  input  logic             is_lsb_ok,
  input  logic [ROB_W-1:0] rob_id_from_lsb,
  input  logic [31:0]      res_from_lsb,
  input  logic             is_rob_commit,
  input  logic [ROB_W-1:0] rob_id_from_rob,
  input  logic [31:0]      res_from_rob
);

  typedef struct packed {
    logic             r;
    logic [ROB_W-1:0] q;
    logic [31:0]      v;
  } opnd_t;

  // {hit, value} for a tag against the three broadcast buses. Matching buses
  // carry the same value; the later assignments give ALU the final say.
  function automatic logic [32:0] bcast_match(
    input logic [ROB_W-1:0] tag,
    input logic             a_ok,
    input logic [ROB_W-1:0] a_id,
    input logic [31:0]      a_res,
    input logic             l_ok,
    input logic [ROB_W-1:0] l_id,
    input logic [31:0]      l_res,
    input logic             c_ok,
    input logic [ROB_W-1:0] c_id,
    input logic [31:0]      c_res
  );
    logic [32:0] m;
    m = '0;
    if (c_ok && c_id == tag) m = {1'b1, c_res};
    if (l_ok && l_id == tag) m = {1'b1, l_res};
    if (a_ok && a_id == tag) m = {1'b1, a_res};
    return m;
  endfunction

  // Operand resolution at load, in priority order: unused/x0, regfile, ROB,
  // same-cycle broadcast, otherwise wait on the producing tag.
  function automatic opnd_t resolve(
    input logic             use_rs,
    input logic [4:0]       rs,
    input logic             busy,
    input logic [ROB_W-1:0] tag,
    input logic [31:0]      rf_val,
    input logic             q_ready,
    input logic [31:0]      q_val,
    input logic [32:0]      hit
  );
    opnd_t o;
    o   = '0;
    o.r = 1'b1;
    if (!use_rs || rs == 5'd0) o.v = '0;
    else if (!busy)            o.v = rf_val;
    else if (q_ready)          o.v = q_val;
    else if (hit[32])          o.v = hit[31:0];
    else begin
      o.r = 1'b0;
      o.q = tag;
    end
    return o;
  endfunction

  // Wakeup of a waiting operand by a matching broadcast.
  function automatic opnd_t wakeup(input opnd_t o, input logic [32:0] hit);
    opnd_t w;
    w = o;
    if (!o.r && hit[32]) begin
      w.r = 1'b1;
      w.q = '0;
      w.v = hit[31:0];
    end
    return w;
  endfunction

  logic             stage_valid;
  logic [5:0]       st_opcode;
  logic [ROB_W-1:0] st_rob_id;
  logic [31:0]      st_imm;
  logic [31:0]      st_pc;
  logic             st_is_mem;
  opnd_t            st_op1;
  opnd_t            st_op2;

  logic [32:0] hit_rf1, hit_rf2, hit_st1, hit_st2;
  opnd_t       new_op1, new_op2, cur_op1, cur_op2;
  logic        kill, fire, load;

  assign hit_rf1 = bcast_match(rf_tag1, is_alu_ok, rob_id_from_alu, res_from_alu,
                               is_lsb_ok, rob_id_from_lsb, res_from_lsb,
                               is_rob_commit, rob_id_from_rob, res_from_rob);
  assign hit_rf2 = bcast_match(rf_tag2, is_alu_ok, rob_id_from_alu, res_from_alu,
                               is_lsb_ok, rob_id_from_lsb, res_from_lsb,
                               is_rob_commit, rob_id_from_rob, res_from_rob);
  assign hit_st1 = bcast_match(st_op1.q, is_alu_ok, rob_id_from_alu, res_from_alu,
                               is_lsb_ok, rob_id_from_lsb, res_from_lsb,
                               is_rob_commit, rob_id_from_rob, res_from_rob);
  assign hit_st2 = bcast_match(st_op2.q, is_alu_ok, rob_id_from_alu, res_from_alu,
                               is_lsb_ok, rob_id_from_lsb, res_from_lsb,
                               is_rob_commit, rob_id_from_rob, res_from_rob);

  // Operands read the pre-rename mapping, so rd==rs sees the old producer.
  assign new_op1 = resolve(iq_use_rs1, iq_rs1, rf_busy1, rf_tag1, rf_val1,
                           rob_q1_ready, rob_q1_val, hit_rf1);
  assign new_op2 = resolve(iq_use_rs2, iq_rs2, rf_busy2, rf_tag2, rf_val2,
                           rob_q2_ready, rob_q2_val, hit_rf2);

  // The staged operands with this cycle's broadcasts folded in; these feed
  // both the issue bus and the next-state of a held instruction.
  assign cur_op1 = wakeup(st_op1, hit_st1);
  assign cur_op2 = wakeup(st_op2, hit_st2);

  // Reset/flush kills every handshake in the same cycle.
  assign kill     = rst || clear;
  assign fire     = rdy && !kill && stage_valid && (st_is_mem ? !lsb_full : !rs_full);
  assign iq_ready = rdy && !kill && !rob_full && (!stage_valid || fire);
  assign load     = iq_valid && iq_ready;

  assign rob_alloc  = load;
  assign rob_opcode = iq_opcode;
  assign rob_rd     = iq_rd;
  assign rob_pc     = iq_pc;

  assign rename_en  = load && (iq_rd != 5'd0);
  assign rename_rd  = iq_rd;
  assign rename_tag = rob_tail;

  assign is_issue     = fire && !st_is_mem;
  assign lsb_issue    = fire && st_is_mem;
  assign issue_opcode = st_opcode;
  assign issue_rob_id = st_rob_id;
  assign issue_Vi     = cur_op1.v;
  assign issue_Qi     = cur_op1.q;
  assign issue_Ri     = cur_op1.r;
  assign issue_Vj     = cur_op2.v;
  assign issue_Qj     = cur_op2.q;
  assign issue_Rj     = cur_op2.r;
  assign issue_imm    = st_imm;
  assign issue_pc     = st_pc;

  always_ff @(posedge clk) begin
    if (kill) begin
      stage_valid <= 1'b0;
      st_opcode   <= '0;
      st_rob_id   <= '0;
      st_imm      <= '0;
      st_pc       <= '0;
      st_is_mem   <= 1'b0;
      st_op1      <= '0;
      st_op2      <= '0;
    end else if (rdy) begin
      if (load) begin
        stage_valid <= 1'b1;
        st_opcode   <= iq_opcode;
        st_rob_id   <= rob_tail;
        st_imm      <= iq_imm;
        st_pc       <= iq_pc;
        st_is_mem   <= iq_is_mem;
        st_op1      <= new_op1;
        st_op2      <= new_op2;
      end else begin
        if (fire) stage_valid <= 1'b0;
        st_op1 <= cur_op1;
        st_op2 <= cur_op2;
      end
    end
  end

endmodule

// File: tb/tb_dispatcher.sv
// tb/tb_dispatcher.sv - self-checking bench for dispatcher
//
// Drives the DUT ports directly; issue payloads are checked against a queue
// of expected records pushed at load time.

module tb_dispatcher;

  logic        clk, rst, rdy, clear;
  logic        iq_valid;
  logic [5:0]  iq_opcode;
  logic [4:0]  iq_rd, iq_rs1, iq_rs2;
  logic [31:0] iq_imm, iq_pc;
  logic        iq_use_rs1, iq_use_rs2, iq_is_mem;
  logic        iq_ready;
  logic        rf_busy1, rf_busy2;
  logic [3:0]  rf_tag1, rf_tag2;
  logic [31:0] rf_val1, rf_val2;
  logic        rename_en;
  logic [4:0]  rename_rd;
  logic [3:0]  rename_tag;
  logic        rob_full;
  logic [3:0]  rob_tail;
  logic        rob_q1_ready, rob_q2_ready;
  logic [31:0] rob_q1_val, rob_q2_val;
  logic        rob_alloc;
  logic [5:0]  rob_opcode;
  logic [4:0]  rob_rd;
  logic [31:0] rob_pc;
  logic        rs_full, lsb_full;
  logic        is_issue, lsb_issue;
  logic [5:0]  issue_opcode;
  logic [3:0]  issue_rob_id, issue_Qi, issue_Qj;
  logic [31:0] issue_Vi, issue_Vj, issue_imm, issue_pc;
  logic        issue_Ri, issue_Rj;
  logic        is_alu_ok, is_lsb_ok, is_rob_commit;
  logic [3:0]  rob_id_from_alu, rob_id_from_lsb, rob_id_from_rob;
  logic [31:0] res_from_alu, res_from_lsb, res_from_rob;

  dispatcher #(.ROB_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .iq_valid(iq_valid), .iq_opcode(iq_opcode), .iq_rd(iq_rd), .iq_rs1(iq_rs1),
    .iq_rs2(iq_rs2), .iq_imm(iq_imm), .iq_pc(iq_pc), .iq_use_rs1(iq_use_rs1),
    .iq_use_rs2(iq_use_rs2), .iq_is_mem(iq_is_mem), .iq_ready(iq_ready),
    .rf_busy1(rf_busy1), .rf_busy2(rf_busy2), .rf_tag1(rf_tag1), .rf_tag2(rf_tag2),
    .rf_val1(rf_val1), .rf_val2(rf_val2),
    .rename_en(rename_en), .rename_rd(rename_rd), .rename_tag(rename_tag),
    .rob_full(rob_full), .rob_tail(rob_tail),
    .rob_q1_ready(rob_q1_ready), .rob_q2_ready(rob_q2_ready),
    .rob_q1_val(rob_q1_val), .rob_q2_val(rob_q2_val),
    .rob_alloc(rob_alloc), .rob_opcode(rob_opcode), .rob_rd(rob_rd), .rob_pc(rob_pc),
    .rs_full(rs_full), .lsb_full(lsb_full), .is_issue(is_issue), .lsb_issue(lsb_issue),
    .issue_opcode(issue_opcode), .issue_rob_id(issue_rob_id),
    .issue_Vi(issue_Vi), .issue_Qi(issue_Qi), .issue_Ri(issue_Ri),
    .issue_Vj(issue_Vj), .issue_Qj(issue_Qj), .issue_Rj(issue_Rj),
    .issue_imm(issue_imm), .issue_pc(issue_pc),
    .is_alu_ok(is_alu_ok), .rob_id_from_alu(rob_id_from_alu), .res_from_alu(res_from_alu),
    .is_lsb_ok(is_lsb_ok), .rob_id_from_lsb(rob_id_from_lsb), .res_from_lsb(res_from_lsb),
    .is_rob_commit(is_rob_commit), .rob_id_from_rob(rob_id_from_rob), .res_from_rob(res_from_rob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [5:0]  op;
    logic [3:0]  id;
    logic [31:0] vi, vj;
    logic        ri, rj;
    logic [3:0]  qi, qj;
    logic        mem;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    string       name;
    logic        v;
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic        u1, u2, mem;
    logic [31:0] val1, val2;
    logic [3:0]  tail;
    logic        robf, rsf, lsbf;
    logic        e_rdy, e_alloc, e_ren, e_is, e_lsb;
  } row_t;

  row_t rows[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [5:0] op, input logic [3:0] id,
                          input logic [31:0] vi, input logic ri, input logic [3:0] qi,
                          input logic [31:0] vj, input logic rj, input logic [3:0] qj,
                          input logic mem);
    exp_t e;
    e.op = op; e.id = id; e.vi = vi; e.ri = ri; e.qi = qi;
    e.vj = vj; e.rj = rj; e.qj = qj; e.mem = mem;
    sb.push_back(e);
  endtask

  task automatic idle();
    rst = 0; rdy = 1; clear = 0;
    iq_valid = 0; iq_opcode = 0; iq_rd = 0; iq_rs1 = 0; iq_rs2 = 0;
    iq_imm = 0; iq_pc = 0; iq_use_rs1 = 0; iq_use_rs2 = 0; iq_is_mem = 0;
    rf_busy1 = 0; rf_busy2 = 0; rf_tag1 = 0; rf_tag2 = 0; rf_val1 = 0; rf_val2 = 0;
    rob_full = 0; rob_tail = 0; rob_q1_ready = 0; rob_q2_ready = 0;
    rob_q1_val = 0; rob_q2_val = 0; rs_full = 0; lsb_full = 0;
    is_alu_ok = 0; rob_id_from_alu = 0; res_from_alu = 0;
    is_lsb_ok = 0; rob_id_from_lsb = 0; res_from_lsb = 0;
    is_rob_commit = 0; rob_id_from_rob = 0; res_from_rob = 0;
  endtask

  task automatic instr(input logic [5:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic mem);
    iq_valid = 1; iq_opcode = op; iq_rd = rd; iq_rs1 = rs1; iq_rs2 = rs2;
    iq_use_rs1 = 1; iq_use_rs2 = 1; iq_is_mem = mem;
    iq_imm = {26'd0, op} + 32'h100; iq_pc = {27'd0, rd, 2'b00};
  endtask

  // Sample at the falling edge: strobes plus scoreboard on any issue.
  task automatic at_neg(input string n, input logic e_rdy, input logic e_alloc,
                        input logic e_ren, input logic [3:0] e_tag,
                        input logic e_is, input logic e_lsb);
    exp_t e;
    @(negedge clk);
    chk({n, ".iq_ready"}, 32'(iq_ready), 32'(e_rdy));
    chk({n, ".rob_alloc"}, 32'(rob_alloc), 32'(e_alloc));
    chk({n, ".rename_en"}, 32'(rename_en), 32'(e_ren));
    chk({n, ".is_issue"}, 32'(is_issue), 32'(e_is));
    chk({n, ".lsb_issue"}, 32'(lsb_issue), 32'(e_lsb));
    if (e_ren) begin
      chk({n, ".rename_tag"}, 32'(rename_tag), 32'(e_tag));
      chk({n, ".rename_rd"}, 32'(rename_rd), 32'(iq_rd));
    end
    if (e_alloc) chk({n, ".rob_rd"}, 32'(rob_rd), 32'(iq_rd));
    if (is_issue || lsb_issue) begin
      if (sb.size() == 0) begin
        chk({n, ".issue_unexpected"}, 32'(is_issue | lsb_issue), 32'd0);
      end else begin
        e = sb.pop_front();
        chk({n, ".issue_mem"}, 32'(lsb_issue), 32'(e.mem));
        chk({n, ".issue_opcode"}, 32'(issue_opcode), 32'(e.op));
        chk({n, ".issue_rob_id"}, 32'(issue_rob_id), 32'(e.id));
        chk({n, ".issue_Ri"}, 32'(issue_Ri), 32'(e.ri));
        chk({n, ".issue_Rj"}, 32'(issue_Rj), 32'(e.rj));
        if (e.ri) chk({n, ".issue_Vi"}, issue_Vi, e.vi);
        else      chk({n, ".issue_Qi"}, 32'(issue_Qi), 32'(e.qi));
        if (e.rj) chk({n, ".issue_Vj"}, issue_Vj, e.vj);
        else      chk({n, ".issue_Qj"}, 32'(issue_Qj), 32'(e.qj));
      end
    end
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string n, input logic e_rdy, input logic e_alloc,
                     input logic e_ren, input logic [3:0] e_tag,
                     input logic e_is, input logic e_lsb);
    at_neg(n, e_rdy, e_alloc, e_ren, e_tag, e_is, e_lsb);
    to_pos();
  endtask

  function automatic row_t mk(input string name, input logic v, input logic [5:0] op,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic mem,
                              input logic [31:0] val1, input logic [31:0] val2,
                              input logic [3:0] tail, input logic robf, input logic rsf,
                              input logic lsbf, input logic e_rdy, input logic e_alloc,
                              input logic e_ren, input logic e_is, input logic e_lsb);
    row_t r;
    r.name = name; r.v = v; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    r.u1 = u1; r.u2 = u2; r.mem = mem; r.val1 = val1; r.val2 = val2; r.tail = tail;
    r.robf = robf; r.rsf = rsf; r.lsbf = lsbf; r.e_rdy = e_rdy; r.e_alloc = e_alloc;
    r.e_ren = e_ren; r.e_is = e_is; r.e_lsb = e_lsb;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //            name           v  op     rd  rs1 rs2 u1 u2 mem val1      val2      tail robf rsf lsbf  rdy al ren is lsb
    rows.push_back(mk("add_load",    1, 6'h01, 3,  1,  2,  1, 1, 0, 32'd5,    32'd7,    3,   0,   0,  0,    1, 1, 1, 0, 0));
    rows.push_back(mk("add_issue",   0, 6'h00, 0,  0,  0,  0, 0, 0, 32'd0,    32'd0,    0,   0,   0,  0,    1, 0, 0, 1, 0));
    rows.push_back(mk("ld_load",     1, 6'h10, 5,  1,  0,  1, 0, 1, 32'h100,  32'h0,    0,   0,   0,  0,    1, 1, 1, 0, 0));
    rows.push_back(mk("st_load",     1, 6'h11, 0,  2,  3,  1, 1, 1, 32'h200,  32'hAB,   1,   0,   0,  0,    1, 1, 0, 0, 1));
    rows.push_back(mk("add2_load",   1, 6'h01, 7,  4,  0,  1, 1, 0, 32'h11,   32'hDEAD, 2,   0,   0,  0,    1, 1, 1, 0, 1));
    rows.push_back(mk("add2_issue",  0, 6'h00, 0,  0,  0,  0, 0, 0, 32'd0,    32'd0,    0,   0,   0,  0,    1, 0, 0, 1, 0));
    rows.push_back(mk("sub_load",    1, 6'h02, 1,  1,  2,  1, 1, 0, 32'd3,    32'd4,    4,   0,   0,  0,    1, 1, 1, 0, 0));
    rows.push_back(mk("robfull",     1, 6'h01, 2,  1,  2,  1, 1, 0, 32'd1,    32'd1,    5,   1,   0,  0,    0, 0, 0, 1, 0));
    rows.push_back(mk("robfull_mt",  1, 6'h01, 2,  1,  2,  1, 1, 0, 32'd1,    32'd1,    5,   1,   0,  0,    0, 0, 0, 0, 0));
    rows.push_back(mk("mem_load",    1, 6'h10, 6,  3,  0,  1, 0, 1, 32'h40,   32'h0,    5,   0,   0,  0,    1, 1, 1, 0, 0));
    rows.push_back(mk("lsbfull",     1, 6'h01, 8,  1,  2,  1, 1, 0, 32'd1,    32'd2,    6,   0,   0,  1,    0, 0, 0, 0, 0));
    rows.push_back(mk("lsb_release", 1, 6'h01, 9,  1,  2,  1, 1, 0, 32'd1,    32'd2,    6,   0,   0,  0,    1, 1, 1, 0, 1));
    rows.push_back(mk("alu_issue",   0, 6'h00, 0,  0,  0,  0, 0, 0, 32'd0,    32'd0,    0,   0,   0,  0,    1, 0, 0, 1, 0));
    rows.push_back(mk("mem_load2",   1, 6'h11, 0,  1,  2,  1, 1, 1, 32'd8,    32'd9,    7,   0,   0,  0,    1, 1, 0, 0, 0));
    rows.push_back(mk("rsfull_mem",  0, 6'h00, 0,  0,  0,  0, 0, 0, 32'd0,    32'd0,    0,   0,   1,  0,    1, 0, 0, 0, 1));

    // Reset with a pending instruction on the queue.
    idle();
    rst = 1;
    instr(6'h01, 5'd1, 5'd1, 5'd2, 1'b0);
    to_pos();
    cyc("reset", 0, 0, 0, 4'd0, 0, 0);
    idle();
    cyc("post_reset", 1, 0, 0, 4'd0, 0, 0);

    // Table-driven single-cycle vectors.
    foreach (rows[i]) begin
      idle();
      iq_valid = rows[i].v; iq_opcode = rows[i].op; iq_rd = rows[i].rd;
      iq_rs1 = rows[i].rs1; iq_rs2 = rows[i].rs2; iq_use_rs1 = rows[i].u1;
      iq_use_rs2 = rows[i].u2; iq_is_mem = rows[i].mem;
      rf_val1 = rows[i].val1; rf_val2 = rows[i].val2; rob_tail = rows[i].tail;
      rob_full = rows[i].robf; rs_full = rows[i].rsf; lsb_full = rows[i].lsbf;
      if (rows[i].e_alloc)
        push_exp(rows[i].op, rows[i].tail,
                 (rows[i].u1 && rows[i].rs1 != 0) ? rows[i].val1 : 32'd0, 1'b1, 4'd0,
                 (rows[i].u2 && rows[i].rs2 != 0) ? rows[i].val2 : 32'd0, 1'b1, 4'd0,
                 rows[i].mem);
      cyc(rows[i].name, rows[i].e_rdy, rows[i].e_alloc, rows[i].e_ren,
          rows[i].tail, rows[i].e_is, rows[i].e_lsb);
    end

    // rs1 waits on tag 2; held by rs_full, then woken by ALU in the issue cycle.
    idle();
    instr(6'h01, 5'd4, 5'd3, 5'd1, 1'b0);
    rf_busy1 = 1; rf_tag1 = 4'd2; rf_val1 = 32'hBAD; rf_val2 = 32'd10;
    rob_tail = 4'd8; rs_full = 1;
    push_exp(6'h01, 4'd8, 32'h55, 1'b1, 4'd0, 32'd10, 1'b1, 4'd0, 1'b0);
    cyc("a_load", 1, 1, 1, 4'd8, 0, 0);
    idle(); rs_full = 1;
    at_neg("a_hold", 0, 0, 0, 4'd0, 0, 0);
    chk("a_hold.issue_Ri", 32'(issue_Ri), 32'd0);
    chk("a_hold.issue_Qi", 32'(issue_Qi), 32'd2);
    to_pos();
    idle(); is_alu_ok = 1; rob_id_from_alu = 4'd2; res_from_alu = 32'h55;
    cyc("a_fire", 1, 0, 0, 4'd0, 1, 0);
    idle();
    cyc("a_after", 1, 0, 0, 4'd0, 0, 0);

    // rs2 waits on tag 4; LSB result arrives during a 3-cycle rs_full hold.
    idle();
    instr(6'h03, 5'd5, 5'd1, 5'd2, 1'b0);
    rf_val1 = 32'd3; rf_busy2 = 1; rf_tag2 = 4'd4; rob_tail = 4'd9;
    push_exp(6'h03, 4'd9, 32'd3, 1'b1, 4'd0, 32'd9, 1'b1, 4'd0, 1'b0);
    cyc("b_load", 1, 1, 1, 4'd9, 0, 0);
    idle(); instr(6'h01, 5'd6, 5'd1, 5'd2, 1'b0); rob_tail = 4'd10; rs_full = 1;
    is_lsb_ok = 1; rob_id_from_lsb = 4'd4; res_from_lsb = 32'd9;
    cyc("b_hold1", 0, 0, 0, 4'd0, 0, 0);
    is_lsb_ok = 0; res_from_lsb = 32'd0;
    cyc("b_hold2", 0, 0, 0, 4'd0, 0, 0);
    at_neg("b_hold3", 0, 0, 0, 4'd0, 0, 0);
    chk("b_hold3.issue_Rj", 32'(issue_Rj), 32'd1);
    chk("b_hold3.issue_Vj", issue_Vj, 32'd9);
    to_pos();
    idle();
    cyc("b_release", 1, 0, 0, 4'd0, 1, 0);

    // ROB-ready and commit-broadcast resolution at load; rd==rs1 uses old mapping.
    idle();
    instr(6'h04, 5'd3, 5'd3, 5'd4, 1'b0);
    rf_busy1 = 1; rf_tag1 = 4'd5; rf_val1 = 32'hBAD; rob_q1_ready = 1; rob_q1_val = 32'h77;
    rf_busy2 = 1; rf_tag2 = 4'd6; rf_val2 = 32'hBAD;
    is_rob_commit = 1; rob_id_from_rob = 4'd6; res_from_rob = 32'h99;
    is_alu_ok = 1; rob_id_from_alu = 4'd7; res_from_alu = 32'h1234;
    rob_tail = 4'd11;
    push_exp(6'h04, 4'd11, 32'h77, 1'b1, 4'd0, 32'h99, 1'b1, 4'd0, 1'b0);
    cyc("c_load", 1, 1, 1, 4'd11, 0, 0);
    idle();
    cyc("c_issue", 1, 0, 0, 4'd0, 1, 0);

    // Flush drops a stalled instruction; nothing issues after rs_full drops.
    idle();
    instr(6'h01, 5'd2, 5'd1, 5'd2, 1'b0); rob_tail = 4'd12;
    cyc("d_load", 1, 1, 1, 4'd12, 0, 0);
    idle(); rs_full = 1;
    cyc("d_hold", 0, 0, 0, 4'd0, 0, 0);
    instr(6'h01, 5'd3, 5'd1, 5'd2, 1'b0); rob_tail = 4'd13; clear = 1;
    cyc("d_clear", 0, 0, 0, 4'd0, 0, 0);
    idle();
    cyc("d_after", 1, 0, 0, 4'd0, 0, 0);
    cyc("d_after2", 1, 0, 0, 4'd0, 0, 0);

    // rdy=0 freezes both load and fire.
    idle();
    instr(6'h05, 5'd1, 5'd1, 5'd0, 1'b0);
    iq_use_rs2 = 0; rf_val1 = 32'h123; rob_tail = 4'd14;
    push_exp(6'h05, 4'd14, 32'h123, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 1'b0);
    cyc("e_load", 1, 1, 1, 4'd14, 0, 0);
    idle(); instr(6'h01, 5'd2, 5'd1, 5'd2, 1'b0); rob_tail = 4'd15; rdy = 0;
    cyc("e_freeze", 0, 0, 0, 4'd0, 0, 0);
    idle();
    cyc("e_fire", 1, 0, 0, 4'd0, 1, 0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
